// File: rtl/mby_tag_uc_rx.sv
// mby_tag_uc_rx: unicast tag receiver. Tags addressed to cfg_port_id are pushed
// into a small FIFO (same-edge write, no fall-through) and drained through a
// valid/ready port. Accepted and overflow-dropped tags are counted (saturating).
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   tag_valid/tag_dst/tag_data  ring tag input
//   tag_par                     even parity over {tag_dst,tag_data}
//   cfg_port_id                 local port ID (quasi-static)
//   out_valid/out_ready/out_data FIFO head handshake
//   fifo_level                  current occupancy
//   acc_cnt, drop_cnt           saturating accept / overflow-drop counters
//   ovf_sticky                  set on first overflow drop
//   par_err_cnt                 saturating parity-error drop counter
//
// Configuration macro: MBY_TAG_UC_RX_PARITY_EN enables the parity check;
// without it tag_par is ignored and par_err_cnt is tied to 0.
module mby_tag_uc_rx #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DST_W  = 5,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tag_valid,
  input  logic [DST_W-1:0]         tag_dst,
  input  logic [DATA_W-1:0]        tag_data,
  input  logic                     tag_par,
  input  logic [DST_W-1:0]         cfg_port_id,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              acc_cnt,
  output logic [15:0]              drop_cnt,
  output logic                     ovf_sticky,
  output logic [15:0]              par_err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 16;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     level_q, level_d;
  logic              out_valid_q, out_valid_d;
  logic [CW-1:0]     acc_q, acc_d, drop_q, drop_d;
  logic              ovf_q, ovf_d;

  logic match_c, par_bad_c, take_c, pop_c, full_c, push_c, drop_c;

`ifdef MBY_TAG_UC_RX_PARITY_EN
  logic [CW-1:0] par_err_q, par_err_d;
  // Received parity must equal the XOR of the protected fields.
  assign par_bad_c = match_c && (tag_par != ^{tag_dst, tag_data});
`else
  logic unused_tag_par;
  assign unused_tag_par = tag_par;
  assign par_bad_c      = 1'b0;
`endif

  // Decode: match, pop, and whether a match fits (a same-cycle pop frees a slot).
  always_comb begin
    match_c = tag_valid && (tag_dst == cfg_port_id);
    take_c  = match_c && !par_bad_c;
    pop_c   = out_valid_q && out_ready;
    full_c  = (level_q == LW'(DEPTH));
    push_c  = take_c && (!full_c || pop_c);
    drop_c  = take_c && full_c && !pop_c;
  end

  // Next-state for pointers, level and counters.
  always_comb begin
    wr_d        = wr_q;
    rd_d        = rd_q;
    level_d     = level_q;
    acc_d       = acc_q;
    drop_d      = drop_q;
    ovf_d       = ovf_q;
    if (push_c) wr_d = wr_q + AW'(1);
    if (pop_c)  rd_d = rd_q + AW'(1);
    level_d     = level_q + LW'(push_c) - LW'(pop_c);
    out_valid_d = (level_d != '0);
    if (push_c && (acc_q != '1)) acc_d = acc_q + CW'(1);
    if (drop_c) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      drop_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage needs no reset; validity is tracked by level/out_valid.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_q] <= tag_data;
  end

`ifdef MBY_TAG_UC_RX_PARITY_EN
  always_comb begin
    par_err_d = par_err_q;
    if (par_bad_c && (par_err_q != '1)) par_err_d = par_err_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= '0;
    else        par_err_q <= par_err_d;
  end

  assign par_err_cnt = par_err_q;
`else
  assign par_err_cnt = '0;
`endif

  assign out_valid  = out_valid_q;
  assign out_data   = mem_q[rd_q];
  assign fifo_level = level_q;
  assign acc_cnt    = acc_q;
  assign drop_cnt   = drop_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_mby_tag_uc_rx.sv
// Scoreboard bench for mby_tag_uc_rx (default parameters).
module tb_mby_tag_uc_rx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tag_valid;
  logic [4:0]  tag_dst;
  logic [63:0] tag_data;
  logic        tag_par;
  logic [4:0]  cfg_port_id;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  fifo_level;
  logic [15:0] acc_cnt;
  logic [15:0] drop_cnt;
  logic        ovf_sticky;
  logic [15:0] par_err_cnt;

  mby_tag_uc_rx dut (
    .clk(clk), .rst_n(rst_n),
    .tag_valid(tag_valid), .tag_dst(tag_dst), .tag_data(tag_data), .tag_par(tag_par),
    .cfg_port_id(cfg_port_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_level(fifo_level), .acc_cnt(acc_cnt), .drop_cnt(drop_cnt),
    .ovf_sticky(ovf_sticky), .par_err_cnt(par_err_cnt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] sb [$];
  logic [15:0] exp_acc, exp_drop, exp_par;
  logic        exp_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    sb.delete();
    exp_acc  = '0;
    exp_drop = '0;
    exp_par  = '0;
    exp_ovf  = 1'b0;
  endtask

  // One clock: drive a tag (or idle), update the model, check the popped head.
  task automatic cycle(input logic v, input logic [4:0] dst, input logic [63:0] data,
                       input logic bad_par);
    logic pop_m, match_m, drop_m;
    tag_valid = v;
    tag_dst   = dst;
    tag_data  = data;
    tag_par   = (^{dst, data}) ^ bad_par;
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    pop_m   = (sb.size() != 0) && out_ready;
    if (pop_m) check("pop_data", out_data, sb[0]);
    match_m = v && (dst == cfg_port_id);
`ifdef MBY_TAG_UC_RX_PARITY_EN
    if (match_m && bad_par) begin
      match_m = 1'b0;
      if (exp_par != 16'hFFFF) exp_par = exp_par + 16'd1;
    end
`endif
    drop_m = match_m && (sb.size() == DEPTH) && !pop_m;
    if (pop_m) void'(sb.pop_front());
    if (match_m && !drop_m) begin
      sb.push_back(data);
      if (exp_acc != 16'hFFFF) exp_acc = exp_acc + 16'd1;
    end
    if (drop_m) begin
      exp_ovf = 1'b1;
      if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
    end
    step();
    tag_valid = 1'b0;
  endtask

  task automatic check_state(input string t);
    check({t, "_level"}, 64'(fifo_level), 64'(sb.size()));
    check({t, "_valid"}, 64'(out_valid), 64'(sb.size() != 0));
    check({t, "_acc"}, 64'(acc_cnt), 64'(exp_acc));
    check({t, "_drop"}, 64'(drop_cnt), 64'(exp_drop));
    check({t, "_ovf"}, 64'(ovf_sticky), 64'(exp_ovf));
    check({t, "_par"}, 64'(par_err_cnt), 64'(exp_par));
    if (sb.size() != 0) check({t, "_head"}, out_data, sb[0]);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    while (sb.size() != 0) cycle(1'b0, 5'd0, 64'd0, 1'b0);
    out_ready = 1'b0;
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic do_reset(input string t);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_state(t);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; tag_valid = 1'b0; tag_dst = '0; tag_data = '0; tag_par = 1'b0;
    cfg_port_id = 5'd3; out_ready = 1'b0;
    model_clear();
    step(); step();
    check_state("por");
    rst_n = 1'b1;

    // Single matching tag
    cycle(1'b1, 5'd3, 64'hA5, 1'b0);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_data", out_data, 64'hA5);
    check("t1_acc", 64'(acc_cnt), 64'd1);
    drain();
    check_state("t1_end");

    // Non-matching then matching
    do_reset("t2_rst");
    cycle(1'b1, 5'd4, 64'h1111, 1'b0);
    check("t2_nomatch_level", 64'(fifo_level), 64'd0);
    cycle(1'b1, 5'd3, 64'h2222, 1'b0);
    check("t2_level", 64'(fifo_level), 64'd1);
    check("t2_acc", 64'(acc_cnt), 64'd1);
    check("t2_drop", 64'(drop_cnt), 64'd0);
    drain();

    // Overflow: 10 pushes into 8 entries, head held stable
    do_reset("t3_rst");
    for (int i = 0; i < 10; i++) cycle(1'b1, 5'd3, 64'(32'hC000 + i), 1'b0);
    check("t3_level", 64'(fifo_level), 64'd8);
    check("t3_drop", 64'(drop_cnt), 64'd2);
    check("t3_ovf", 64'(ovf_sticky), 64'd1);
    check("t3_head", out_data, 64'hC000);
    check_state("t3");
    drain();
    check_state("t3_end");

    // Full FIFO, match and pop in the same cycle
    do_reset("t4_rst");
    for (int i = 0; i < 8; i++) cycle(1'b1, 5'd3, 64'(32'hD000 + i), 1'b0);
    out_ready = 1'b1;
    cycle(1'b1, 5'd3, 64'hD0FF, 1'b0);
    out_ready = 1'b0;
    check("t4_level", 64'(fifo_level), 64'd8);
    check("t4_drop", 64'(drop_cnt), 64'd0);
    check("t4_acc", 64'(acc_cnt), 64'd9);
    check_state("t4");
    drain();
    check_state("t4_end");

    // Async reset with 5 entries queued, then first tag after release
    do_reset("t5_pre");
    for (int i = 0; i < 5; i++) cycle(1'b1, 5'd3, 64'(32'hE000 + i), 1'b0);
    check("t5_level_before", 64'(fifo_level), 64'd5);
    do_reset("t5_async");
    cycle(1'b1, 5'd3, 64'hF00D, 1'b0);
    check("t5_first_level", 64'(fifo_level), 64'd1);
    check("t5_first_acc", 64'(acc_cnt), 64'd1);
    check("t5_first_data", out_data, 64'hF00D);
    drain();

    // Wrong parity on a matching tag
    do_reset("t6_rst");
    cycle(1'b1, 5'd3, 64'h5A5A, 1'b1);
`ifdef MBY_TAG_UC_RX_PARITY_EN
    check("t6_par_err", 64'(par_err_cnt), 64'd1);
    check("t6_level", 64'(fifo_level), 64'd0);
`else
    check("t6_par_err", 64'(par_err_cnt), 64'd0);
    check("t6_level", 64'(fifo_level), 64'd1);
`endif
    check_state("t6");
    drain();

    // Mixed random traffic
    do_reset("t7_rst");
    for (int i = 0; i < 200; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(2, 4)), {$urandom, $urandom}, 1'b0);
    end
    out_ready = 1'b0;
    check_state("t7");
    drain();

    // acc_cnt saturation
    do_reset("t8_rst");
    out_ready = 1'b1;
    for (int i = 0; i < 65538; i++) cycle(1'b1, 5'd3, 64'(i), 1'b0);
    out_ready = 1'b0;
    check("t8_acc_sat", 64'(acc_cnt), 64'hFFFF);
    check_state("t8");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
